// File: rtl/axi_node_cfg_loader.sv
// AXI-Lite master that replays a (addr, data, strb) table into the node config regfile.
// Optional readback verify: define CFG_LOADER_VERIFY_EN.
module axi_node_cfg_loader #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int N_ENTRIES   = 64,
  parameter int TIMEOUT_CYC = 256,
  localparam int IDX_W = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [IDX_W-1:0]      err_idx_o,
  output logic [IDX_W-1:0]      tbl_idx_o,
  input  logic [ADDR_WIDTH-1:0] tbl_addr_i,
  input  logic [DATA_WIDTH-1:0] tbl_data_i,
  input  logic [3:0]            tbl_strb_i,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_FETCH = 4'd1;
  localparam logic [3:0] S_WRITE = 4'd2;
  localparam logic [3:0] S_BRESP = 4'd3;
`ifdef CFG_LOADER_VERIFY_EN
  localparam logic [3:0] S_AR    = 4'd4;
  localparam logic [3:0] S_R     = 4'd5;
`endif
  localparam logic [3:0] S_NEXT  = 4'd6;
  localparam logic [3:0] S_DONE  = 4'd7;
  localparam logic [3:0] S_ERR   = 4'd8;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ENTRIES - 1);

  localparam bit WD_EN = (TIMEOUT_CYC > 0);
  localparam int WD_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  logic [3:0]            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [3:0]            strb_q, strb_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  error_q, error_d;
  logic [IDX_W-1:0]      err_idx_q, err_idx_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic                  wd_to;

  assign wd_to = WD_EN && (wd_q == WD_LAST);

`ifdef CFG_LOADER_VERIFY_EN
  logic arvalid_q, arvalid_d;
  logic rready_q, rready_d;
  logic rd_mismatch;

  // Readback compare, only on bytes this record actually wrote
  always_comb begin
    rd_mismatch = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (strb_q[b] && (m_axi_rdata[8*b +: 8] != data_q[8*b +: 8]))
        rd_mismatch = 1'b1;
    end
  end

  assign m_axi_araddr  = addr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
`else
  logic unused_rd;
  assign unused_rd = ^{m_axi_arready, m_axi_rdata,
                       m_axi_rresp, m_axi_rvalid};
  assign m_axi_araddr  = '0;
  assign m_axi_arvalid = 1'b0;
  assign m_axi_rready  = 1'b0;
`endif

  // Sequencer next-state; each wait state can bail to ERR on watchdog
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    error_d   = error_q;
    err_idx_d = err_idx_q;
`ifdef CFG_LOADER_VERIFY_EN
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_FETCH;
          idx_d   = '0;
          error_d = 1'b0;
        end
      end
      S_FETCH: begin
        addr_d = tbl_addr_i;
        data_d = tbl_data_i;
        strb_d = tbl_strb_i;
        if (tbl_strb_i == 4'h0) begin
          state_d = S_DONE;
        end else begin
          state_d   = S_WRITE;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
        end
      end
      S_WRITE: begin
        awvalid_d = awvalid_q & ~m_axi_awready;
        wvalid_d  = wvalid_q & ~m_axi_wready;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = S_BRESP;
          bready_d = 1'b1;
        end else if (wd_to) begin
          state_d   = S_ERR;
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
        end
      end
      S_BRESP: begin
        if (m_axi_bvalid) begin
          bready_d = 1'b0;
          if (m_axi_bresp != 2'b00) begin
            state_d = S_ERR;
          end else begin
`ifdef CFG_LOADER_VERIFY_EN
            state_d   = S_AR;
            arvalid_d = 1'b1;
`else
            state_d = S_NEXT;
`endif
          end
        end else if (wd_to) begin
          state_d  = S_ERR;
          bready_d = 1'b0;
        end
      end
`ifdef CFG_LOADER_VERIFY_EN
      S_AR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_R;
        end else if (wd_to) begin
          arvalid_d = 1'b0;
          state_d   = S_ERR;
        end
      end
      S_R: begin
        if (m_axi_rvalid) begin
          rready_d = 1'b0;
          if ((m_axi_rresp != 2'b00) || rd_mismatch)
            state_d = S_ERR;
          else
            state_d = S_NEXT;
        end else if (wd_to) begin
          rready_d = 1'b0;
          state_d  = S_ERR;
        end
      end
`endif
      S_NEXT: begin
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_FETCH;
        end
      end
      S_DONE: state_d = S_IDLE;
      S_ERR: begin
        error_d   = 1'b1;
        err_idx_d = idx_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    wd_d = (state_d != state_q) ? '0 : wd_q + WD_W'(1);
  end

  // State and datapath registers
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      error_q   <= 1'b0;
      err_idx_q <= '0;
      wd_q      <= '0;
`ifdef CFG_LOADER_VERIFY_EN
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      error_q   <= error_d;
      err_idx_q <= err_idx_d;
      wd_q      <= wd_d;
`ifdef CFG_LOADER_VERIFY_EN
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
`endif
    end
  end

  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);
  assign error_o       = error_q;
  assign err_idx_o     = err_idx_q;
  assign tbl_idx_o     = idx_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = data_q;
  assign m_axi_wstrb   = strb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;

endmodule

// File: tb/tb_axi_node_cfg_loader.sv
// Bench for axi_node_cfg_loader: vector table of runs plus
// hand sequences for watchdog, reset, restart, full table, verify.
module tb_axi_node_cfg_loader;
  localparam int N  = 8;
  localparam int IW = 3;
`ifdef CFG_LOADER_VERIFY_EN
  localparam int T1_CYC = 20;
`else
  localparam int T1_CYC = 14;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic busy, done, error;
  logic [IW-1:0] err_idx, tbl_idx;
  logic [31:0] t_addr [N];
  logic [31:0] t_data [N];
  logic [3:0]  t_strb [N];
  logic [31:0] tbl_addr, tbl_data;
  logic [3:0]  tbl_strb;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic awvalid, awready, wvalid, wready;
  logic bvalid, bready, arvalid, arready, rvalid, rready;
  logic [1:0] bresp, rresp;

  assign tbl_addr = t_addr[tbl_idx];
  assign tbl_data = t_data[tbl_idx];
  assign tbl_strb = t_strb[tbl_idx];

  axi_node_cfg_loader #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .N_ENTRIES(N), .TIMEOUT_CYC(16)
  ) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rstn),
    .start_i(start), .busy_o(busy), .done_o(done),
    .error_o(error), .err_idx_o(err_idx),
    .tbl_idx_o(tbl_idx), .tbl_addr_i(tbl_addr),
    .tbl_data_i(tbl_data), .tbl_strb_i(tbl_strb),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready), .m_axi_wdata(wdata),
    .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid),
    .m_axi_wready(wready), .m_axi_bresp(bresp),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid),
    .m_axi_arready(arready), .m_axi_rdata(rdata),
    .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
    .m_axi_rready(rready)
  );

  // slave model knobs (driven by main)
  int aw_dly = 0;
  int w_dly = 0;
  int bad = -1;
  bit allow_drop = 1'b0;
  bit rb_ovr = 1'b0;
  logic [31:0] rb_val = 32'h0;

  // slave-owned state and observation log
  int awc, wc;
  logic aw_got, w_got;
  logic [31:0] a_q, d_q, last_wd;
  logic [3:0] s_q;
  logic ah, wh;
  logic [31:0] ca, cd;
  logic [3:0] cs;
  logic awv_p, awr_p, wv_p, wr_p;
  logic [31:0] awaddr_p, wdata_p;
  logic [3:0] wstrb_p;
  logic [31:0] o_a [256];
  logic [31:0] o_d [256];
  logic [3:0]  o_s [256];
  int obs_n = 0;
  int aw_hs = 0;
  int w_hs = 0;
  int ar_hs = 0;
  int stab_err = 0;

  assign awready = awvalid && (awc >= aw_dly);
  assign wready  = wvalid && (wc >= w_dly);
  assign arready = arvalid;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      awc <= 0; wc <= 0;
      aw_got <= 1'b0; w_got <= 1'b0;
      bvalid <= 1'b0; bresp <= 2'b00;
      rvalid <= 1'b0; rresp <= 2'b00; rdata <= 32'h0;
      awv_p <= 1'b0; awr_p <= 1'b0;
      wv_p <= 1'b0; wr_p <= 1'b0;
      last_wd <= 32'h0;
    end else begin
      awc <= (awvalid && !awready) ? awc + 1 : 0;
      wc  <= (wvalid && !wready) ? wc + 1 : 0;
      if (awv_p && !awr_p && !allow_drop &&
          (!awvalid || awaddr != awaddr_p)) stab_err++;
      if (wv_p && !wr_p && !allow_drop &&
          (!wvalid || wdata != wdata_p || wstrb != wstrb_p)) stab_err++;
      awv_p <= awvalid; awr_p <= awready; awaddr_p <= awaddr;
      wv_p <= wvalid; wr_p <= wready;
      wdata_p <= wdata; wstrb_p <= wstrb;
      if (bvalid && bready) bvalid <= 1'b0;
      if (awvalid && awready) begin aw_hs++; a_q <= awaddr; end
      if (wvalid && wready) begin w_hs++; d_q <= wdata; s_q <= wstrb; end
      ah = aw_got || (awvalid && awready);
      wh = w_got || (wvalid && wready);
      if (ah && wh) begin
        ca = aw_got ? a_q : awaddr;
        cd = w_got ? d_q : wdata;
        cs = w_got ? s_q : wstrb;
        o_a[obs_n % 256] = ca;
        o_d[obs_n % 256] = cd;
        o_s[obs_n % 256] = cs;
        obs_n++;
        aw_got <= 1'b0; w_got <= 1'b0;
        bvalid <= 1'b1;
        bresp <= (int'(tbl_idx) == bad) ? 2'b10 : 2'b00;
        last_wd <= cd;
      end else begin
        if (awvalid && awready) aw_got <= 1'b1;
        if (wvalid && wready) w_got <= 1'b1;
      end
      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid && arready) begin
        ar_hs++;
        rvalid <= 1'b1; rresp <= 2'b00;
        rdata <= rb_ovr ? rb_val : last_wd;
      end
    end
  end

  typedef struct { logic [31:0] a; logic [31:0] d; logic [3:0] s; } wr_t;
  typedef struct { int aw; int w; int bad; int nwr; int err; int eidx; } vec_t;

  wr_t exp_q[$];
  int rd_ptr = 0;
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic drain();
    wr_t e;
    while (rd_ptr < obs_n) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_write: addr %0h data %0h",
                 o_a[rd_ptr % 256], o_d[rd_ptr % 256]);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", o_a[rd_ptr % 256], e.a);
        chk("wr_data", o_d[rd_ptr % 256], e.d);
        chk("wr_strb", {28'h0, o_s[rd_ptr % 256]}, {28'h0, e.s});
      end
      rd_ptr++;
    end
  endtask

  task automatic push_exp(input int n);
    wr_t e;
    for (int i = 0; i < n; i++) begin
      e.a = t_addr[i]; e.d = t_data[i]; e.s = t_strb[i];
      exp_q.push_back(e);
    end
  endtask

  task automatic load3();
    for (int i = 0; i < N; i++) begin
      t_addr[i] = 32'(i); t_data[i] = 32'h0; t_strb[i] = 4'h0;
    end
    t_data[0] = 32'h1000; t_strb[0] = 4'hF;
    t_data[1] = 32'h1FFF; t_strb[1] = 4'hF;
    t_data[2] = 32'h0001; t_strb[2] = 4'hF;
  endtask

  task automatic kick();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", {31'h0, busy}, 32'h1);
    chk("err_clr_on_start", {31'h0, error}, 32'h0);
  endtask

  task automatic run_wait(input int budget, output int dn, output int cyc);
    dn = 0; cyc = 0;
    while (busy && cyc < budget) begin
      @(negedge clk);
      if (done) dn++;
      drain();
      cyc++;
    end
    if (busy) begin
      n_chk++;
      $display("FAIL run_timeout: busy still %0b after %0d cycles", busy, cyc);
    end
  endtask

  task automatic chk_rst();
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_error", {31'h0, error}, 32'h0);
    chk("rst_err_idx", {29'h0, err_idx}, 32'h0);
    chk("rst_tbl_idx", {29'h0, tbl_idx}, 32'h0);
    chk("rst_valids", {27'h0, awvalid, wvalid, bready, arvalid, rready}, 32'h0);
    chk("rst_awaddr", awaddr, 32'h0);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_wstrb", {28'h0, wstrb}, 32'h0);
    chk("rst_araddr", araddr, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end

  initial begin
    vec_t vecs[6];
    int dn, cyc, b_aw, b_w, b_st, b_ar, c;
    vecs[0] = '{aw:0, w:0, bad:-1, nwr:3, err:0, eidx:0};
    vecs[1] = '{aw:5, w:0, bad:-1, nwr:3, err:0, eidx:0};
    vecs[2] = '{aw:0, w:5, bad:-1, nwr:3, err:0, eidx:0};
    vecs[3] = '{aw:3, w:3, bad:-1, nwr:3, err:0, eidx:0};
    vecs[4] = '{aw:0, w:0, bad:1,  nwr:2, err:1, eidx:1};
    vecs[5] = '{aw:2, w:0, bad:0,  nwr:1, err:1, eidx:0};
    load3();
    repeat (3) @(negedge clk);
    chk_rst();
    rstn = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      load3();
      aw_dly = vecs[v].aw; w_dly = vecs[v].w; bad = vecs[v].bad;
      b_aw = aw_hs; b_w = w_hs; b_st = stab_err;
      push_exp(vecs[v].nwr);
      kick();
      run_wait(400, dn, cyc);
      drain();
      if (v == 0) chk("t1_cycles", cyc, T1_CYC);
      chk("done_pulses", dn, (vecs[v].err != 0) ? 0 : 1);
      chk("error", {31'h0, error}, vecs[v].err);
      if (vecs[v].err != 0) chk("err_idx", {29'h0, err_idx}, vecs[v].eidx);
      chk("aw_hs", aw_hs - b_aw, vecs[v].nwr);
      chk("w_hs", w_hs - b_w, vecs[v].nwr);
      chk("valid_stable", stab_err - b_st, 0);
      chk("sb_empty", exp_q.size(), 0);
      exp_q.delete();
    end

    // start while busy is ignored
    load3(); aw_dly = 0; w_dly = 0; bad = -1;
    b_aw = aw_hs;
    push_exp(3);
    kick();
    repeat (3) @(negedge clk);
    drain();
    start = 1'b1; @(negedge clk); start = 1'b0;
    run_wait(400, dn, cyc);
    drain();
    chk("busy_start_done", dn, 1);
    chk("busy_start_aw_hs", aw_hs - b_aw, 3);
    chk("busy_start_sb_empty", exp_q.size(), 0);
    exp_q.delete();

    // full table, no terminator
    for (int i = 0; i < N; i++) begin
      t_addr[i] = 32'h100 + 32'(4 * i);
      t_data[i] = $urandom;
      t_strb[i] = 4'(i + 1);
    end
    b_aw = aw_hs;
    push_exp(N);
    kick();
    run_wait(600, dn, cyc);
    drain();
    chk("full_done", dn, 1);
    chk("full_error", {31'h0, error}, 32'h0);
    chk("full_aw_hs", aw_hs - b_aw, N);
    chk("full_sb_empty", exp_q.size(), 0);
    exp_q.delete();

    // watchdog on a stuck AW channel
    load3(); aw_dly = 100000; w_dly = 0; bad = -1;
    allow_drop = 1'b1;
    b_aw = aw_hs;
    kick();
    @(negedge clk);
    chk("wd_awvalid_rise", {31'h0, awvalid}, 32'h1);
    c = 0;
    while (awvalid && c < 100) begin c++; @(negedge clk); end
    chk("wd_cycles", c, 16);
    run_wait(50, dn, cyc);
    chk("wd_error", {31'h0, error}, 32'h1);
    chk("wd_err_idx", {29'h0, err_idx}, 32'h0);
    chk("wd_busy", {31'h0, busy}, 32'h0);
    chk("wd_aw_hs", aw_hs - b_aw, 0);
    @(negedge clk); rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;
    allow_drop = 1'b0; aw_dly = 0;
    drain();

    // async reset during WRITE of entry 2, then restart
    load3(); aw_dly = 5; w_dly = 0;
    push_exp(3);
    kick();
    c = 0;
    while (!(tbl_idx == 3'd2 && awvalid) && c < 200) begin
      @(negedge clk); drain(); c++;
    end
    chk("reached_entry2", {29'h0, tbl_idx}, 32'h2);
    #2 rstn = 1'b0;
    #1;
    chk_rst();
    drain();
    chk("rst_partial_left", exp_q.size(), 1);
    exp_q.delete();
    @(negedge clk); rstn = 1'b1;
    aw_dly = 0;
    push_exp(3);
    kick();
    chk("restart_idx0", {29'h0, tbl_idx}, 32'h0);
    run_wait(400, dn, cyc);
    drain();
    chk("restart_done", dn, 1);
    chk("restart_error", {31'h0, error}, 32'h0);
    chk("restart_sb_empty", exp_q.size(), 0);
    exp_q.delete();

`ifdef CFG_LOADER_VERIFY_EN
    // readback verify with strobe masking
    load3();
    t_data[0] = 32'h0000_1000; t_strb[0] = 4'b0001;
    t_strb[1] = 4'h0;
    rb_ovr = 1'b1; rb_val = 32'h0000_1001;
    b_ar = ar_hs;
    push_exp(1);
    kick();
    run_wait(200, dn, cyc);
    drain();
    chk("vfy_bad_error", {31'h0, error}, 32'h1);
    chk("vfy_bad_err_idx", {29'h0, err_idx}, 32'h0);
    chk("vfy_bad_done", dn, 0);
    chk("vfy_ar_hs", ar_hs - b_ar, 1);
    rb_val = 32'hFFFF_FF00;
    push_exp(1);
    kick();
    run_wait(200, dn, cyc);
    drain();
    chk("vfy_ok_error", {31'h0, error}, 32'h0);
    chk("vfy_ok_done", dn, 1);
    chk("vfy_sb_empty", exp_q.size(), 0);
    exp_q.delete();
    rb_ovr = 1'b0;
`else
    chk("no_ar_issued", ar_hs, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
